// File: rtl/shade_unit.sv
// Two-stage valid/ready shading stage: scales each RGB channel of a hit record by a
// per-face brightness from a runtime-writable table, with saturation on the way out.
module shade_unit #(
    parameter int COLOR_W   = 8,
    parameter int BRIGHT_W  = 4,
    parameter int FRAC_BITS = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_hit,
    input  logic [2:0]             in_face_id,
    input  logic [3*COLOR_W-1:0]   in_color,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_hit,
    output logic [3*COLOR_W-1:0]   out_color,
    input  logic                   cfg_we,
    input  logic [2:0]             cfg_addr,
    input  logic [BRIGHT_W-1:0]    cfg_data
);

    localparam int                PROD_W  = COLOR_W + BRIGHT_W;
    localparam logic [PROD_W-1:0] SAT_MAX = PROD_W'((1 << COLOR_W) - 1);

    function automatic logic [BRIGHT_W-1:0] default_bright(input int idx);
        case (idx)
            0, 1:    return BRIGHT_W'(2);
            2:       return BRIGHT_W'(4);
            3:       return BRIGHT_W'(1);
            4, 5:    return BRIGHT_W'(3);
            default: return '0;
        endcase
    endfunction

    function automatic logic [COLOR_W-1:0] shade_chan(input logic [COLOR_W-1:0]  c,
                                                      input logic [BRIGHT_W-1:0] b);
        logic [PROD_W-1:0] p;
        logic [PROD_W-1:0] s;
        p = PROD_W'(c) * PROD_W'(b);
        s = p >> FRAC_BITS;
        return (s > SAT_MAX) ? {COLOR_W{1'b1}} : s[COLOR_W-1:0];
    endfunction

    logic [BRIGHT_W-1:0]  bright_q [8];

    logic                 s1_valid_q, s1_valid_d;
    logic                 s1_hit_q,   s1_hit_d;
    logic [3*COLOR_W-1:0] s1_color_q, s1_color_d;
    logic [BRIGHT_W-1:0]  s1_bright_q, s1_bright_d;
    logic                 s2_valid_q, s2_valid_d;
    logic                 s2_hit_q,   s2_hit_d;
    logic [3*COLOR_W-1:0] s2_color_q, s2_color_d;

    logic                 s1_adv, s2_adv, accept;
    logic [BRIGHT_W-1:0]  lookup_b;
    logic [3*COLOR_W-1:0] shaded;

    // NOTE: the table is reset (not left as plain storage) because its default contents are architectural.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) bright_q[i] <= default_bright(i);
        end else if (cfg_we) begin
            bright_q[cfg_addr] <= cfg_data;
        end
    end

    assign s2_adv   = !s2_valid_q || out_ready;
    assign s1_adv   = !s1_valid_q || s2_adv;
    assign in_ready = s1_adv;
    assign accept   = in_valid && s1_adv;

    // Lookup sees the pre-write table, so a same-cycle cfg write only affects later records.
    assign lookup_b = in_hit ? bright_q[in_face_id] : '0;

    always_comb begin
        shaded = '0;
        for (int ch = 0; ch < 3; ch++) begin
            shaded[ch*COLOR_W +: COLOR_W] = shade_chan(s1_color_q[ch*COLOR_W +: COLOR_W], s1_bright_q);
        end
    end

    // NOTE: every next-state signal takes its hold value first, so no path leaves it unassigned (no latch).
    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_hit_d    = s1_hit_q;
        s1_color_d  = s1_color_q;
        s1_bright_d = s1_bright_q;
        s2_valid_d  = s2_valid_q;
        s2_hit_d    = s2_hit_q;
        s2_color_d  = s2_color_q;
        if (s1_adv) begin
            s1_valid_d = in_valid;
            if (accept) begin
                s1_hit_d    = in_hit;
                s1_color_d  = in_color;
                s1_bright_d = lookup_b;
            end
        end
        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_hit_d   = s1_hit_q;
                s2_color_d = shaded;
            end
        end
    end

    // NOTE: state registers use non-blocking assignment so all stages update from the same pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_hit_q    <= 1'b0;
            s1_color_q  <= '0;
            s1_bright_q <= '0;
            s2_valid_q  <= 1'b0;
            s2_hit_q    <= 1'b0;
            s2_color_q  <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_hit_q    <= s1_hit_d;
            s1_color_q  <= s1_color_d;
            s1_bright_q <= s1_bright_d;
            s2_valid_q  <= s2_valid_d;
            s2_hit_q    <= s2_hit_d;
            s2_color_q  <= s2_color_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign out_hit   = s2_hit_q;
    assign out_color = s2_color_q;

endmodule

// File: tb/tb_shade_unit.sv
// Self-checking bench for shade_unit: directed scenarios plus randomized traffic
// scored against a behavioural model of the brightness table and shading arithmetic.
module tb_shade_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        in_hit;
    logic [2:0]  in_face_id;
    logic [23:0] in_color;
    logic        out_valid;
    logic        out_ready;
    logic        out_hit;
    logic [23:0] out_color;
    logic        cfg_we;
    logic [2:0]  cfg_addr;
    logic [3:0]  cfg_data;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic        hit;
        logic [23:0] color;
    } exp_t;

    int   model_tab [8];
    exp_t exp_q [$];

    always #5 clk = ~clk;

    shade_unit #(.COLOR_W(8), .BRIGHT_W(4), .FRAC_BITS(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_hit     (in_hit),
        .in_face_id (in_face_id),
        .in_color   (in_color),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_hit    (out_hit),
        .out_color  (out_color),
        .cfg_we     (cfg_we),
        .cfg_addr   (cfg_addr),
        .cfg_data   (cfg_data)
    );

    function automatic void init_model();
        model_tab = '{2, 2, 4, 1, 3, 3, 0, 0};
    endfunction

    // Brightness is a fixed-point gain with 2 fraction bits; result clips at 255.
    function automatic logic [23:0] model_shade(input logic hit, input logic [2:0] face,
                                                input logic [23:0] c);
        int          b;
        int          v;
        logic [23:0] r;
        b = hit ? model_tab[face] : 0;
        r = '0;
        for (int ch = 0; ch < 3; ch++) begin
            v = int'(c[ch*8 +: 8]) * b / 4;
            if (v > 255) v = 255;
            r[ch*8 +: 8] = 8'(v);
        end
        return r;
    endfunction

    // Drives one record, waits for it to be accepted and to emerge; ok=0 if the budget runs out.
    task automatic send_one(input logic hit, input logic [2:0] face, input logic [23:0] col,
                            output logic [23:0] oc, output logic oh, output bit ok);
        bit taken;
        int n;
        taken = 0;
        n     = 0;
        ok    = 0;
        oc    = '0;
        oh    = 1'b0;
        in_valid = 1'b1; in_hit = hit; in_face_id = face; in_color = col; out_ready = 1'b1;
        while (!taken && n < 20) begin
            @(negedge clk);
            taken = in_ready;
            @(posedge clk); #1;
            n++;
        end
        in_valid = 1'b0;
        while (!ok && n < 40) begin
            @(negedge clk);
            if (out_valid) begin
                oc = out_color;
                oh = out_hit;
                ok = 1;
            end
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; cfg_we = 1'b0; out_ready = 1'b1;
        in_hit = 1'b0; in_face_id = '0; in_color = '0; cfg_addr = '0; cfg_data = '0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++;
        if (out_hit !== 1'b0) begin errors++; $display("FAIL reset_out_hit: got %b want 0", out_hit); end
        checks++;
        if (out_color !== 24'h0) begin errors++; $display("FAIL reset_out_color: got %h want 000000", out_color); end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        @(posedge clk); #1;
        init_model();
    endtask

    task automatic test_default_table();
        logic [23:0] exp_c [8];
        int          sent, got, cyc, first_acc;
        exp_c = '{ {8'd100, 8'd50, 8'd20}, {8'd100, 8'd50, 8'd20}, {8'd200, 8'd100, 8'd40},
                   {8'd50, 8'd25, 8'd10},  {8'd150, 8'd75, 8'd30}, {8'd150, 8'd75, 8'd30},
                   24'h0, 24'h0 };
        sent = 0; got = 0; cyc = 0; first_acc = -1;
        out_ready = 1'b1;
        while (got < 8 && cyc < 50) begin
            in_valid   = (sent < 8);
            in_hit     = 1'b1;
            in_face_id = 3'(sent);
            in_color   = {8'd200, 8'd100, 8'd40};
            @(negedge clk);
            if (out_valid) begin
                checks++;
                if (out_color !== exp_c[got] || out_hit !== 1'b1) begin
                    errors++;
                    $display("FAIL default_face%0d: got hit=%b color=%h want hit=1 color=%h",
                             got, out_hit, out_color, exp_c[got]);
                end
                checks++;
                if (cyc != first_acc + 2 + got) begin
                    errors++;
                    $display("FAIL default_latency%0d: got cycle %0d want %0d", got, cyc, first_acc + 2 + got);
                end
                got++;
            end
            if (in_valid && in_ready) begin
                if (sent == 0) first_acc = cyc;
                sent++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        in_valid = 1'b0;
        checks++;
        if (got != 8) begin errors++; $display("FAIL default_count: got %0d outputs want 8", got); end
    endtask

    task automatic test_miss();
        logic [23:0] oc;
        logic        oh;
        bit          ok;
        send_one(1'b0, 3'd2, 24'hFFFFFF, oc, oh, ok);
        checks++;
        if (!ok || oc !== 24'h0 || oh !== 1'b0) begin
            errors++;
            $display("FAIL miss: got ok=%0d hit=%b color=%h want ok=1 hit=0 color=000000", ok, oh, oc);
        end
    endtask

    task automatic test_saturation();
        logic [23:0] oc;
        logic        oh;
        bit          ok;
        cfg_we = 1'b1; cfg_addr = 3'd2; cfg_data = 4'd15;
        @(posedge clk); #1;
        cfg_we = 1'b0;
        model_tab[2] = 15;
        send_one(1'b1, 3'd2, {8'd255, 8'd64, 8'd0}, oc, oh, ok);
        checks++;
        if (!ok || oc !== {8'd255, 8'd240, 8'd0} || oh !== 1'b1) begin
            errors++;
            $display("FAIL saturation: got ok=%0d hit=%b color=%h want ok=1 hit=1 color=fff000", ok, oh, oc);
        end
    endtask

    task automatic test_same_cycle_cfg();
        logic [23:0] oc;
        logic        oh;
        bit          ok;
        int          n;
        out_ready = 1'b1;
        in_valid = 1'b1; in_hit = 1'b1; in_face_id = 3'd4; in_color = {8'd10, 8'd10, 8'd10};
        cfg_we = 1'b1; cfg_addr = 3'd4; cfg_data = 4'd8;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL samecfg_accept: got in_ready=%b want 1", in_ready); end
        @(posedge clk); #1;
        in_valid = 1'b0; cfg_we = 1'b0;
        model_tab[4] = 8;
        ok = 0; n = 0; oc = '0;
        while (!ok && n < 10) begin
            @(negedge clk);
            if (out_valid) begin oc = out_color; ok = 1; end
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (!ok || oc !== {8'd7, 8'd7, 8'd7}) begin
            errors++;
            $display("FAIL samecfg_old: got ok=%0d color=%h want ok=1 color=070707", ok, oc);
        end
        send_one(1'b1, 3'd4, {8'd10, 8'd10, 8'd10}, oc, oh, ok);
        checks++;
        if (!ok || oc !== {8'd20, 8'd20, 8'd20}) begin
            errors++;
            $display("FAIL samecfg_new: got ok=%0d color=%h want ok=1 color=141414", ok, oc);
        end
    endtask

    task automatic test_backpressure();
        logic        pat [6];
        logic [23:0] held_c;
        logic        held_h;
        logic        exp_rdy;
        bit          stalled;
        exp_t        e;
        int          sent, got, cyc;
        logic [23:0] rec_c [6];
        logic [2:0]  rec_f [6];
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 6; i++) begin
            rec_c[i] = 24'($urandom);
            rec_f[i] = 3'($urandom);
        end
        exp_q.delete();
        sent = 0; got = 0; cyc = 0; stalled = 0; held_c = '0; held_h = 1'b0;
        while (got < 6 && cyc < 200) begin
            out_ready  = pat[cyc % 6];
            in_valid   = (sent < 6);
            in_hit     = 1'b1;
            in_face_id = rec_f[sent % 6];
            in_color   = rec_c[sent % 6];
            @(negedge clk);
            if (stalled) begin
                checks++;
                if (out_valid !== 1'b1 || out_color !== held_c || out_hit !== held_h) begin
                    errors++;
                    $display("FAIL bp_hold: got v=%b c=%h h=%b want v=1 c=%h h=%b",
                             out_valid, out_color, out_hit, held_c, held_h);
                end
            end
            exp_rdy = !(exp_q.size() == 2 && !out_ready);
            checks++;
            if (in_ready !== exp_rdy) begin
                errors++;
                $display("FAIL bp_in_ready: got %b want %b (in flight %0d)", in_ready, exp_rdy, exp_q.size());
            end
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL bp_extra: got color=%h want no output", out_color);
                end else begin
                    e = exp_q.pop_front();
                    if (out_color !== e.color || out_hit !== e.hit) begin
                        errors++;
                        $display("FAIL bp_data%0d: got hit=%b color=%h want hit=%b color=%h",
                                 got, out_hit, out_color, e.hit, e.color);
                    end
                end
                got++;
            end
            stalled = out_valid && !out_ready;
            held_c  = out_color;
            held_h  = out_hit;
            if (in_valid && in_ready) begin
                exp_q.push_back('{hit: in_hit, color: model_shade(in_hit, in_face_id, in_color)});
                sent++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        checks++;
        if (got != 6 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL bp_count: got %0d outputs want 6 (left %0d)", got, exp_q.size());
        end
    endtask

    task automatic test_random();
        logic [23:0] held_c;
        logic        held_h;
        logic        exp_rdy;
        bit          stalled;
        bit          drain;
        exp_t        e;
        exp_q.delete();
        stalled = 0; held_c = '0; held_h = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            drain      = (cyc >= 340);
            in_valid   = !drain && ($urandom_range(0, 9) < 7);
            in_hit     = ($urandom_range(0, 3) != 0);
            in_face_id = 3'($urandom);
            in_color   = 24'($urandom);
            out_ready  = drain || ($urandom_range(0, 2) != 0);
            cfg_we     = !drain && ($urandom_range(0, 3) == 0);
            cfg_addr   = 3'($urandom);
            cfg_data   = 4'($urandom);
            @(negedge clk);
            if (stalled) begin
                checks++;
                if (out_valid !== 1'b1 || out_color !== held_c || out_hit !== held_h) begin
                    errors++;
                    $display("FAIL rnd_hold@%0d: got v=%b c=%h h=%b want v=1 c=%h h=%b",
                             cyc, out_valid, out_color, out_hit, held_c, held_h);
                end
            end
            exp_rdy = !(exp_q.size() == 2 && !out_ready);
            checks++;
            if (in_ready !== exp_rdy) begin
                errors++;
                $display("FAIL rnd_in_ready@%0d: got %b want %b", cyc, in_ready, exp_rdy);
            end
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL rnd_extra@%0d: got color=%h want no output", cyc, out_color);
                end else begin
                    e = exp_q.pop_front();
                    if (out_color !== e.color || out_hit !== e.hit) begin
                        errors++;
                        $display("FAIL rnd_data@%0d: got hit=%b color=%h want hit=%b color=%h",
                                 cyc, out_hit, out_color, e.hit, e.color);
                    end
                end
            end
            stalled = out_valid && !out_ready;
            held_c  = out_color;
            held_h  = out_hit;
            if (in_valid && in_ready) begin
                exp_q.push_back('{hit: in_hit, color: model_shade(in_hit, in_face_id, in_color)});
            end
            if (cfg_we) model_tab[cfg_addr] = int'(cfg_data);
            @(posedge clk); #1;
        end
        in_valid = 1'b0; cfg_we = 1'b0; out_ready = 1'b1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL rnd_drain: got %0d records undelivered want 0", exp_q.size());
        end
    endtask

    task automatic test_mid_reset();
        logic [23:0] oc;
        logic        oh;
        bit          ok;
        out_ready = 1'b0;
        cfg_we = 1'b1; cfg_addr = 3'd0; cfg_data = 4'd15;
        @(posedge clk); #1;
        cfg_we = 1'b0;
        in_valid = 1'b1; in_hit = 1'b1; in_face_id = 3'd0; in_color = 24'($urandom);
        @(posedge clk); #1;
        in_color = 24'($urandom);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL mid_full: got in_ready=%b out_valid=%b want in_ready=0 out_valid=1", in_ready, out_valid);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        cfg_we = 1'b1; cfg_addr = 3'd0; cfg_data = 4'd15;
        @(posedge clk); #1;
        rst = 1'b0; cfg_we = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset: got out_valid=%b in_ready=%b want out_valid=0 in_ready=1", out_valid, in_ready);
        end
        @(posedge clk); #1;
        init_model();
        send_one(1'b1, 3'd0, {8'd8, 8'd8, 8'd8}, oc, oh, ok);
        checks++;
        if (!ok || oc !== {8'd4, 8'd4, 8'd4} || oh !== 1'b1) begin
            errors++;
            $display("FAIL mid_after: got ok=%0d hit=%b color=%h want ok=1 hit=1 color=040404", ok, oh, oc);
        end
    endtask

    initial begin
        init_model();
        test_reset();
        test_default_table();
        test_miss();
        test_saturation();
        test_same_cycle_cfg();
        test_backpressure();
        test_random();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
